// File: rtl/ss_decoder.sv
// rtl/ss_decoder.sv - seven-segment scan decoder: debounce, decode, per-digit hex capture and frame tracking
module ss_decoder #(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            clk_en_i,
    input  logic [3:0]      anode_bits_i,
    input  logic [6:0]      cathode_bits_i,
    output logic [3:0][3:0] bin_o,
    output logic [3:0]      valid_o,
    output logic            frame_o,
    output logic            anode_err_o,
    output logic            pattern_err_o
);

    localparam logic [3:0]  COMMIT_CNT   = 4'(STABLE_CYCLES - 1);
    localparam logic [10:0] SAMPLE_RESET = {4'hF, 7'h7F};

    logic [10:0]      sample_q, sample_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [3:0][3:0]  bin_q, bin_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       seen_q, seen_d;
    logic             frame_q, frame_d;
    logic             anode_err_q, anode_err_d;
    logic             pattern_err_q, pattern_err_d;

    logic [10:0]      sample_new;
    logic             commit;
    logic [1:0]       digit;
    logic             digit_ok;
    logic [3:0]       seg_val;
    logic             seg_ok;
    logic [3:0]       seen_upd;

    assign sample_new = {anode_bits_i, cathode_bits_i};

    always_comb begin
        digit    = 2'd0;
        digit_ok = 1'b1;
        unique case (anode_bits_i)
            4'b1110: digit = 2'd0;
            4'b1101: digit = 2'd1;
            4'b1011: digit = 2'd2;
            4'b0111: digit = 2'd3;
            default: digit_ok = 1'b0;
        endcase
    end

    // Cathodes are active-low {g,f,e,d,c,b,a}; anything off this table is undecodable.
    always_comb begin
        seg_val = 4'h0;
        seg_ok  = 1'b1;
        unique case (cathode_bits_i)
            7'h40: seg_val = 4'h0;
            7'h79: seg_val = 4'h1;
            7'h24: seg_val = 4'h2;
            7'h30: seg_val = 4'h3;
            7'h19: seg_val = 4'h4;
            7'h12: seg_val = 4'h5;
            7'h02: seg_val = 4'h6;
            7'h78: seg_val = 4'h7;
            7'h00: seg_val = 4'h8;
            7'h10: seg_val = 4'h9;
            7'h08: seg_val = 4'hA;
            7'h03: seg_val = 4'hB;
            7'h46: seg_val = 4'hC;
            7'h21: seg_val = 4'hD;
            7'h06: seg_val = 4'hE;
            7'h0E: seg_val = 4'hF;
            default: seg_ok = 1'b0;
        endcase
    end

    always_comb begin
        sample_d      = sample_q;
        cnt_d         = cnt_q;
        done_d        = done_q;
        bin_d         = bin_q;
        valid_d       = valid_q;
        seen_d        = seen_q;
        frame_d       = 1'b0;
        anode_err_d   = 1'b0;
        pattern_err_d = 1'b0;
        commit        = 1'b0;
        seen_upd      = seen_q | (4'b0001 << digit);

        if (clk_en_i) begin
            if (sample_new == sample_q) begin
                cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
            end else begin
                sample_d = sample_new;
                cnt_d    = 4'd0;
                done_d   = 1'b0;
            end

            // done flag keeps a long stable run from committing more than once
            commit = (cnt_d == COMMIT_CNT) && !done_d;

            if (commit) begin
                done_d = 1'b1;
                if (anode_bits_i == 4'b1111) begin
                    done_d = 1'b1;
                end else if (!digit_ok) begin
                    anode_err_d = 1'b1;
                end else if (!seg_ok) begin
                    pattern_err_d = 1'b1;
                end else begin
                    bin_d[digit]   = seg_val;
                    valid_d[digit] = 1'b1;
                    if (seen_upd == 4'b1111) begin
                        frame_d = 1'b1;
                        seen_d  = 4'b0000;
                    end else begin
                        seen_d = seen_upd;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sample_q      <= SAMPLE_RESET;
            cnt_q         <= 4'd0;
            done_q        <= 1'b0;
            bin_q         <= '0;
            valid_q       <= 4'b0000;
            seen_q        <= 4'b0000;
            frame_q       <= 1'b0;
            anode_err_q   <= 1'b0;
            pattern_err_q <= 1'b0;
        end else begin
            sample_q      <= sample_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            bin_q         <= bin_d;
            valid_q       <= valid_d;
            seen_q        <= seen_d;
            frame_q       <= frame_d;
            anode_err_q   <= anode_err_d;
            pattern_err_q <= pattern_err_d;
        end
    end

    assign bin_o         = bin_q;
    assign valid_o       = valid_q;
    assign frame_o       = frame_q;
    assign anode_err_o   = anode_err_q;
    assign pattern_err_o = pattern_err_q;

endmodule

// File: tb/tb_ss_decoder.sv
// tb/tb_ss_decoder.sv - scoreboard bench for ss_decoder with directed scan vectors
module tb_ss_decoder;

    logic            clk;
    logic            reset_n;
    logic            clk_en;
    logic [3:0]      anode;
    logic [6:0]      cathode;
    logic [3:0][3:0] bin;
    logic [3:0]      valid;
    logic            frame;
    logic            anode_err;
    logic            pattern_err;

    ss_decoder #(.STABLE_CYCLES(2)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .clk_en_i      (clk_en),
        .anode_bits_i  (anode),
        .cathode_bits_i(cathode),
        .bin_o         (bin),
        .valid_o       (valid),
        .frame_o       (frame),
        .anode_err_o   (anode_err),
        .pattern_err_o (pattern_err)
    );

    typedef struct {
        logic [15:0] bin;
        logic [3:0]  valid;
        logic        frame;
        logic        aerr;
        logic        perr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic [15:0] b, input logic [3:0] v,
                             input logic f, input logic a, input logic p);
        exp_t e;
        e.bin = b; e.valid = v; e.frame = f; e.aerr = a; e.perr = p;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            anode   = a;
            cathode = c;
            @(posedge clk);
            #1;
        end
    endtask

    // Any pulse or change of bin/valid is a DUT event and must match the next expected entry.
    logic [15:0] prev_bin;
    logic [3:0]  prev_valid;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_bin   <= '0;
            prev_valid <= '0;
        end else begin
            if (frame || anode_err || pattern_err || bin != prev_bin || valid != prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {bin, 8'h0, valid, 1'b0, frame, anode_err, pattern_err}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ev_bin",   32'(bin),         32'(e.bin));
                    chk("ev_valid", 32'(valid),       32'(e.valid));
                    chk("ev_frame", 32'(frame),       32'(e.frame));
                    chk("ev_aerr",  32'(anode_err),   32'(e.aerr));
                    chk("ev_perr",  32'(pattern_err), 32'(e.perr));
                end
                chk("pulse_onehot0", 32'($onehot0({frame, anode_err, pattern_err})), 32'd1);
            end
            prev_bin   <= bin;
            prev_valid <= valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        clk_en  = 1'b1;
        anode   = 4'hF;
        cathode = 7'h7F;
        #1;
        chk("reset_bin",   32'(bin),   32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_pulses", 32'({frame, anode_err, pattern_err}), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        expect_ev(16'h0002, 4'b0001, 0, 0, 0);
        drive(4'hE, 7'h24, 2);
        drive(4'hF, 7'h7F, 2);

        drive(4'hD, 7'h30, 1);
        expect_ev(16'h0042, 4'b0011, 0, 0, 0);
        drive(4'hD, 7'h19, 3);

        expect_ev(16'h0041, 4'b0011, 0, 0, 0);
        drive(4'hE, 7'h79, 3);
        expect_ev(16'h0021, 4'b0011, 0, 0, 0);
        drive(4'hD, 7'h24, 3);
        expect_ev(16'h0321, 4'b0111, 0, 0, 0);
        drive(4'hB, 7'h30, 3);
        expect_ev(16'h4321, 4'b1111, 1, 0, 0);
        drive(4'h7, 7'h19, 3);

        expect_ev(16'h4325, 4'b1111, 0, 0, 0);
        drive(4'hE, 7'h12, 3);
        expect_ev(16'h4365, 4'b1111, 0, 0, 0);
        drive(4'hD, 7'h02, 3);
        expect_ev(16'h4765, 4'b1111, 0, 0, 0);
        drive(4'hB, 7'h78, 3);
        expect_ev(16'h8765, 4'b1111, 1, 0, 0);
        drive(4'h7, 7'h00, 3);

        expect_ev(16'h8765, 4'b1111, 0, 0, 1);
        drive(4'hB, 7'h7F, 3);
        expect_ev(16'h8765, 4'b1111, 0, 1, 0);
        drive(4'h3, 7'h40, 3);
        drive(4'hF, 7'h7F, 2);

        expect_ev(16'h8965, 4'b1111, 0, 0, 0);
        drive(4'hB, 7'h10, 3);
        expect_ev(16'h8A65, 4'b1111, 0, 0, 0);
        drive(4'hB, 7'h08, 3);
        expect_ev(16'h8AB5, 4'b1111, 0, 0, 0);
        drive(4'hD, 7'h03, 3);
        expect_ev(16'h8ABC, 4'b1111, 0, 0, 0);
        drive(4'hE, 7'h46, 3);
        expect_ev(16'hDABC, 4'b1111, 1, 0, 0);
        drive(4'h7, 7'h21, 3);
        expect_ev(16'hDABE, 4'b1111, 0, 0, 0);
        drive(4'hE, 7'h06, 3);
        expect_ev(16'hDAFE, 4'b1111, 0, 0, 0);
        drive(4'hD, 7'h0E, 3);
        expect_ev(16'hD0FE, 4'b1111, 0, 0, 0);
        drive(4'hB, 7'h40, 3);

        drive(4'h7, 7'h19, 1);
        reset_n = 1'b0;
        #1;
        chk("midrun_reset_bin",    32'(bin),   32'h0);
        chk("midrun_reset_valid",  32'(valid), 32'h0);
        chk("midrun_reset_pulses", 32'({frame, anode_err, pattern_err}), 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive(4'h7, 7'h19, 1);
        chk("partial_count_discarded", 32'(valid), 32'h0);
        expect_ev(16'h4000, 4'b1000, 0, 0, 0);
        drive(4'h7, 7'h19, 1);
        drive(4'h7, 7'h19, 2);

        anode   = 4'hE;
        cathode = 7'h10;
        for (int i = 0; i < 4; i++) begin
            clk_en = (i == 0);
            @(posedge clk);
            #1;
        end
        chk("gated_no_commit_bin",   32'(bin),   32'h4000);
        chk("gated_no_commit_valid", 32'(valid), 32'h8);
        expect_ev(16'h4009, 4'b1001, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            clk_en = (i == 0);
            @(posedge clk);
            #1;
        end
        clk_en = 1'b1;
        drive(4'hF, 7'h7F, 3);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
